ahb_ssram_ctrl: RTL and testbench
=================================

# ahb_ssram_ctrl

AHB-Lite slave that drives a single-port synchronous write-first SSRAM (32-bit words, one-cycle read latency, single write enable). It is the initiator side of the SSRAM port: converts AHB address/data phases into RAM enable/write/address cycles. It handles byte and halfword writes by read-modify-write and arbitrates the single RAM port between a write's data phase and the next read's address phase. Sits between the AHB interconnect and the on-chip SSRAM macro.

## Interface
- ADDR_WIDTH, 10, RAM word-address width; RAM depth 2^ADDR_WIDTH words.

- HCLK  in  1  clock; all logic on rising edge
- HRESETn  in  1  reset, synchronous, active-low
- HSEL  in  1  slave select
- HADDR  in  32  byte address; RAM word address = HADDR[ADDR_WIDTH+1:2]
- HTRANS  in  2  transfer type; HTRANS[1]=1 (NONSEQ/SEQ) is a valid transfer
- HWRITE  in  1  1=write
- HSIZE  in  3  0=byte, 1=halfword, ≥2 treated as word
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus ready (address phase accepted when high)
- HRDATA  out  32  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  response; tied 0 (OKAY)
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM word address
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM read data, valid one cycle after ram_en & !ram_we

## Operation
- acc = HSEL & HTRANS[1] & HREADY. Address-phase fields latched on acc: word address, HWRITE, HSIZE, HADDR[1:0].
- State = data phase currently in progress: IDLE, RD, RD_ISSUE, WR, RMW_RD, RMW_WR.
- RAM port use per state (ram_en=0 when unused):
  - IDLE / RD: port free. On acc & read: ram_en=1, ram_we=0, ram_addr from live HADDR → next RD. On acc & word write → WR; sub-word write → RMW_RD; no acc → IDLE.
  - WR: ram_en=1, ram_we=1, ram_addr=latched, ram_din=HWDATA. Next: acc & read → RD_ISSUE (read addr latched); acc & word write → WR; acc & sub-word write → RMW_RD; else IDLE.
  - RD_ISSUE: ram_en=1, ram_we=0, ram_addr=latched read addr → RD.
  - RMW_RD: ram_en=1, ram_we=0, ram_addr=latched write addr → RMW_WR.
  - RMW_WR: ram_en=1, ram_we=1, ram_din = ram_dout with selected byte lanes replaced by HWDATA lanes. Next-state rules identical to WR.
- Byte lanes little-endian: HSIZE=0 → lane HADDR[1:0]; HSIZE=1 → lanes {2·HADDR[1], 2·HADDR[1]+1}.
- HREADYOUT: 0 in RD_ISSUE and RMW_RD; 1 in all other states.
- HRDATA = ram_dout in RD, 0 otherwise. Sub-word reads return full word.
- HRESP always 0. No error responses; out-of-range HADDR bits ignored (aliasing).

## Timing
- Reset (HRESETn=0 at edge): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, ram_en=0, ram_we=0; latched fields cleared. Reset in any state (incl. RMW_RD) aborts: no RAM write issued.
- Read: zero wait states when preceded by IDLE/RD/idle bus; one wait state (RD_ISSUE) when address phase coincides with a write data phase.
- Word write: zero wait states; RAM written in the data-phase cycle.
- Sub-word write: one wait state (RMW_RD), RAM written in the following cycle. HWDATA held by master across wait state per AHB.
- Read after write same address: write completes before read issue → new data returned.
- ram_en/ram_we/ram_addr/ram_din are combinational from state, latched fields, HADDR and HWDATA; no combinational path from ram_dout to HREADYOUT.
- Address phase is never accepted by this block while HREADYOUT=0 (HREADY low stalls master).

## Test plan
- Reset: hold HRESETn=0 two cycles → HREADYOUT=1, HRDATA=0, ram_en=0, ram_we=0.
- Word write 0xDEADBEEF to 0x10 then read 0x10 → write cycle ram_we=1, ram_addr=4; read has one wait state (RD_ISSUE), HRDATA=0xDEADBEEF.
- Back-to-back reads 0x0, 0x4, 0x8 (RAM preloaded 0x11,0x22,0x33) → zero wait states, HRDATA 0x11, 0x22, 0x33 on consecutive cycles.
- Byte write 0xAB to 0x21 over word 0x12345678 → HREADYOUT low one cycle, RAM word 8 becomes 0x1234AB78; halfword 0xCAFE to 0x22 → 0xCAFEAB78.
- Alternating write/read/write/read stream → every read returns last written value, wait states only on reads after writes.
- HRESETn=0 during RMW_RD of byte write to 0x30 → no write (ram_we never 1), RAM word 12 unchanged, state IDLE after reset.

Source files
------------

// File: rtl/ahb_ssram_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_ssram_ctrl
// AHB-Lite slave that fronts a single-port, write-first synchronous SRAM
// (32-bit words, one-cycle read latency). Word writes go to the RAM in their
// data phase. Byte and halfword writes use read-modify-write, which costs one
// wait state. A read whose address phase overlaps a write data phase is
// deferred one cycle, because the write owns the RAM port in that cycle.
//
// Ports
//   HCLK, HRESETn            clock, synchronous active-low reset
//   HSEL/HADDR/HTRANS/HWRITE AHB address phase
//   HSIZE/HREADY             AHB address phase (HREADY = bus-wide ready)
//   HWDATA                   AHB write data (data phase)
//   HRDATA/HREADYOUT/HRESP   AHB slave response
//   ram_en/ram_we/ram_addr   SSRAM control (combinational)
//   ram_din                  SSRAM write data (combinational)
//   ram_dout                 SSRAM read data (one cycle after a read enable)
// ---------------------------------------------------------------------------
module ahb_ssram_ctrl #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    input  logic [31:0]           ram_dout
);

    // The state names the data phase currently in progress.
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD       = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_WR       = 3'd3;
    localparam logic [2:0] S_RMW_RD   = 3'd4;
    localparam logic [2:0] S_RMW_WR   = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [2:0]            r_size;
    logic [1:0]            r_bofs;

    logic                  w_acc;
    logic                  w_sub;
    logic [3:0]            w_mask;
    logic [31:0]           w_merge;
    logic                  w_unused_ok;

    assign w_acc = HSEL & HTRANS[1] & HREADY;
    assign w_sub = (HSIZE[2:1] == 2'b00);

    // Upper address bits alias; HTRANS[0] (SEQ vs NONSEQ) is irrelevant here.
    // The latched direction is kept for visibility but is already encoded in
    // the state.
    assign w_unused_ok = &{1'b0, HADDR[31:ADDR_WIDTH+2], HTRANS[0], r_write};

    // Next state
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE, S_RD: begin
                if (w_acc)
                    w_next = !HWRITE ? S_RD : (w_sub ? S_RMW_RD : S_WR);
            end
            // The write holds the port this cycle, so a new read is deferred.
            S_WR, S_RMW_WR: begin
                if (w_acc)
                    w_next = !HWRITE ? S_RD_ISSUE : (w_sub ? S_RMW_RD : S_WR);
            end
            S_RD_ISSUE: w_next = S_RD;
            S_RMW_RD:   w_next = S_RMW_WR;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= 3'd0;
            r_bofs  <= 2'd0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_addr  <= HADDR[ADDR_WIDTH+1:2];
                r_write <= HWRITE;
                r_size  <= HSIZE;
                r_bofs  <= HADDR[1:0];
            end
        end
    end

    // Little-endian lane select for the latched write
    always_comb begin
        w_mask = 4'b1111;
        if (r_size == 3'd0)
            w_mask = 4'b0001 << r_bofs;
        else if (r_size == 3'd1)
            w_mask = r_bofs[1] ? 4'b1100 : 4'b0011;
    end

    always_comb begin
        w_merge = ram_dout;
        for (int i = 0; i < 4; i++)
            if (w_mask[i]) w_merge[8*i +: 8] = HWDATA[8*i +: 8];
    end

    // RAM port
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = r_addr;
        ram_din  = HWDATA;
        case (r_state)
            S_IDLE, S_RD: begin
                // Port is free, so a read is issued straight from the live
                // address phase.
                if (w_acc && !HWRITE) begin
                    ram_en   = 1'b1;
                    ram_addr = HADDR[ADDR_WIDTH+1:2];
                end
            end
            S_WR: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
            end
            S_RD_ISSUE, S_RMW_RD: ram_en = 1'b1;
            S_RMW_WR: begin
                ram_en  = 1'b1;
                ram_we  = 1'b1;
                ram_din = w_merge;
            end
            default: ;
        endcase
    end

    assign HREADYOUT = !(r_state == S_RD_ISSUE || r_state == S_RMW_RD);
    assign HRDATA    = (r_state == S_RD) ? ram_dout : 32'h0;
    assign HRESP     = 1'b0;

endmodule

// File: tb/tb_ahb_ssram_ctrl.sv
module tb_ahb_ssram_ctrl;

    localparam int AW = 10;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 HCLK = ~HCLK;

    // Single slave on the bus: the bus ready is this slave's ready.
    assign HREADY = HREADYOUT;

    ahb_ssram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .HRESP(HRESP), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Write-first SSRAM model with a bench-only preload port
    logic [31:0]   mem [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [31:0]   pl_data = '0;
    logic          mon_on = 1'b0;
    logic          we_seen = 1'b0;

    always @(posedge HCLK) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_din;
                ram_dout      <= ram_din;
            end else
                ram_dout <= mem[ram_addr];
        end
        if (mon_on && ram_we) we_seen <= 1'b1;
    end

    task automatic step();
        @(posedge HCLK); #1;
    endtask

    task automatic samp();
        @(negedge HCLK);
    endtask

    task automatic bus(input logic s, input logic [1:0] t, input logic w,
                       input logic [2:0] sz, input logic [31:0] a);
        HSEL = s; HTRANS = t; HWRITE = w; HSIZE = sz; HADDR = a;
    endtask

    task automatic idle();
        bus(1'b0, 2'b00, 1'b0, 3'd2, 32'h0);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        HRESETn = 1'b0;
        HWDATA  = 32'h0;
        idle();

        // Reset held two cycles
        step(); step();
        samp();
        chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        chk("rst_hrdata",    HRDATA, 32'h0);
        chk("rst_ram_en",    {31'h0, ram_en}, 32'h0);
        chk("rst_ram_we",    {31'h0, ram_we}, 32'h0);
        chk("rst_hresp",     {31'h0, HRESP}, 32'h0);

        step();
        HRESETn = 1'b1;
        preload(10'd0, 32'h11);
        preload(10'd1, 32'h22);
        preload(10'd2, 32'h33);
        preload(10'd8, 32'h12345678);
        preload(10'd12, 32'h55667788);

        // Word write 0x10 then read 0x10
        bus(1'b1, 2'b10, 1'b1, 3'd2, 32'h10);
        step();
        HWDATA = 32'hDEADBEEF;
        bus(1'b1, 2'b10, 1'b0, 3'd2, 32'h10);
        samp();
        chk("wr_we",     {31'h0, ram_we}, 32'h1);
        chk("wr_addr",   {22'h0, ram_addr}, 32'h4);
        chk("wr_din",    ram_din, 32'hDEADBEEF);
        chk("wr_rdy",    {31'h0, HREADYOUT}, 32'h1);
        step();
        idle();
        samp();
        chk("rdi_rdy",   {31'h0, HREADYOUT}, 32'h0);
        chk("rdi_en",    {31'h0, ram_en & ~ram_we}, 32'h1);
        chk("rdi_addr",  {22'h0, ram_addr}, 32'h4);
        step();
        samp();
        chk("rdi_data",  HRDATA, 32'hDEADBEEF);
        chk("rdi_rdy2",  {31'h0, HREADYOUT}, 32'h1);

        // Back-to-back reads
        step();
        bus(1'b1, 2'b10, 1'b0, 3'd2, 32'h0);
        samp();
        chk("b2b_en",    {31'h0, ram_en & ~ram_we}, 32'h1);
        chk("b2b_addr0", {22'h0, ram_addr}, 32'h0);
        step();
        bus(1'b1, 2'b11, 1'b0, 3'd2, 32'h4);
        samp();
        chk("b2b_d0",    HRDATA, 32'h11);
        chk("b2b_rdy0",  {31'h0, HREADYOUT}, 32'h1);
        step();
        bus(1'b1, 2'b11, 1'b0, 3'd2, 32'h8);
        samp();
        chk("b2b_d1",    HRDATA, 32'h22);
        chk("b2b_rdy1",  {31'h0, HREADYOUT}, 32'h1);
        step();
        idle();
        samp();
        chk("b2b_d2",    HRDATA, 32'h33);
        step();
        samp();
        chk("idle_hrdata", HRDATA, 32'h0);

        // Byte write 0xAB to 0x21, then halfword 0xCAFE to 0x22
        step();
        bus(1'b1, 2'b10, 1'b1, 3'd0, 32'h21);
        step();
        idle();
        HWDATA = 32'h0000AB00;
        samp();
        chk("rmw_rdy",   {31'h0, HREADYOUT}, 32'h0);
        chk("rmw_rd",    {30'h0, ram_en, ram_we}, 32'h2);
        chk("rmw_addr",  {22'h0, ram_addr}, 32'h8);
        step();
        bus(1'b1, 2'b10, 1'b1, 3'd1, 32'h22);
        samp();
        chk("rmw_we",    {31'h0, ram_we}, 32'h1);
        chk("rmw_din_b", ram_din, 32'h1234AB78);
        chk("rmw_rdy2",  {31'h0, HREADYOUT}, 32'h1);
        step();
        idle();
        HWDATA = 32'hCAFE0000;
        samp();
        chk("rmw_h_rdy", {31'h0, HREADYOUT}, 32'h0);
        step();
        samp();
        chk("rmw_din_h", ram_din, 32'hCAFEAB78);
        step();
        samp();
        chk("rmw_mem8",  mem[8], 32'hCAFEAB78);

        // Alternating write/read stream to 0x40
        bus(1'b1, 2'b10, 1'b1, 3'd2, 32'h40);
        step();
        HWDATA = 32'hA5A5_0001;
        bus(1'b1, 2'b10, 1'b0, 3'd2, 32'h40);
        samp();
        chk("alt_w1_rdy", {31'h0, HREADYOUT}, 32'h1);
        step();
        bus(1'b1, 2'b10, 1'b1, 3'd2, 32'h40);
        samp();
        chk("alt_r1_wait", {31'h0, HREADYOUT}, 32'h0);
        step();
        samp();
        chk("alt_r1_data", HRDATA, 32'hA5A5_0001);
        chk("alt_r1_rdy",  {31'h0, HREADYOUT}, 32'h1);
        step();
        HWDATA = 32'h5A5A_0002;
        bus(1'b1, 2'b10, 1'b0, 3'd2, 32'h40);
        samp();
        chk("alt_w2_rdy", {31'h0, HREADYOUT}, 32'h1);
        chk("alt_w2_din", ram_din, 32'h5A5A_0002);
        step();
        idle();
        samp();
        chk("alt_r2_wait", {31'h0, HREADYOUT}, 32'h0);
        step();
        samp();
        chk("alt_r2_data", HRDATA, 32'h5A5A_0002);

        // Reset during RMW_RD aborts the byte write to 0x30
        step();
        bus(1'b1, 2'b10, 1'b1, 3'd0, 32'h30);
        step();
        idle();
        HWDATA  = 32'h000000FF;
        HRESETn = 1'b0;
        mon_on  = 1'b1;
        samp();
        chk("abort_rdy_in_rmw", {31'h0, HREADYOUT}, 32'h0);
        step();
        samp();
        chk("abort_rdy",  {31'h0, HREADYOUT}, 32'h1);
        chk("abort_en",   {31'h0, ram_en}, 32'h0);
        step();
        HRESETn = 1'b1;
        step();
        mon_on = 1'b0;
        samp();
        chk("abort_no_we", {31'h0, we_seen}, 32'h0);
        chk("abort_mem12", mem[12], 32'h55667788);
        chk("abort_idle",  HRDATA, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
